// File: rtl/instr_decode_buffer.sv
// Instruction queue between fetch and decode: a circular buffer of {instr, pc}
// with the head entry split into MIPS fields and a saturating refused-push counter.
module instr_decode_buffer #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int DROP_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [PC_W-1:0]            in_pc,
  input  logic                       flush,
  input  logic [1:0]                 ext_sel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [5:0]                 op,
  output logic [4:0]                 rs,
  output logic [4:0]                 rt,
  output logic [4:0]                 rd,
  output logic [4:0]                 shamt,
  output logic [5:0]                 func,
  output logic [15:0]                imm16,
  output logic [31:0]                imm32,
  output logic [25:0]                addr26,
  output logic                       is_r,
  output logic                       is_j,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [DROP_W-1:0]          drop_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]     instr_mem [DEPTH];
  logic [PC_W-1:0] pc_mem    [DEPTH];
  logic [PW-1:0]   wp;
  logic [PW-1:0]   rp;
  logic            push;
  logic            pop;
  logic [31:0]     head_instr;

  // Handshake: a transfer happens on a side when its valid and ready are both
  // high at the rising edge; flush suppresses both transfers in that cycle.
  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count    <= '0;
      wp       <= '0;
      rp       <= '0;
      drop_cnt <= '0;
    end else begin
      if (flush) begin
        count <= '0;
        wp    <= '0;
        rp    <= '0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop)  rp <= rp + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
      if (in_valid && !in_ready && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wp] <= in_instr;
      pc_mem[wp]    <= in_pc;
    end
  end

  assign head_instr = out_valid ? instr_mem[rp] : 32'h0;
  assign out_pc     = out_valid ? pc_mem[rp] : '0;

  assign op     = head_instr[31:26];
  assign rs     = head_instr[25:21];
  assign rt     = head_instr[20:16];
  assign rd     = head_instr[15:11];
  assign shamt  = head_instr[10:6];
  assign func   = head_instr[5:0];
  assign imm16  = head_instr[15:0];
  assign addr26 = head_instr[25:0];
  assign is_r   = out_valid && (op == 6'h00);
  assign is_j   = (op == 6'h02) || (op == 6'h03);

  always_comb begin
    imm32 = {16'h0, imm16};
    case (ext_sel)
      2'b01:   imm32 = {{16{imm16[15]}}, imm16};
      2'b10:   imm32 = {imm16, 16'h0};
      default: imm32 = {16'h0, imm16};
    endcase
  end

endmodule
